// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling per-thread LSU read/write requests onto a single
// data-memory port, one outstanding transaction at a time. Optional grant counter: MEM_ARBITER_PERF_COUNT_EN.
module mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_read_ready,
  input  logic                               mem_write_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               busy
`ifdef MEM_ARBITER_PERF_COUNT_EN
  ,
  output logic [15:0]                        grant_count
`endif
);

  localparam int GW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t                   r_state;
  logic [GW-1:0]            r_grant;
  logic [GW-1:0]            r_last_grant;
  logic                     r_is_read;

  logic [NUM_CONSUMERS-1:0] w_pending;
  logic                     w_found;
  logic [GW-1:0]            w_grant_idx;
  int                       w_cand;
  logic                     w_grant_is_read;
  logic                     w_relay_valid;

  assign w_pending       = consumer_read_valid | consumer_write_valid;
  assign w_grant_is_read = consumer_read_valid[w_grant_idx];
  assign w_relay_valid   = r_is_read ? consumer_read_valid[r_grant] : consumer_write_valid[r_grant];

  // Round-robin search starting one past the last grant.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      w_cand = (int'(r_last_grant) + k) % NUM_CONSUMERS;
      if (!w_found && w_pending[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = GW'(w_cand);
      end else begin
        w_found     = w_found;
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state              <= IDLE;
      r_grant              <= '0;
      r_last_grant         <= GW'(NUM_CONSUMERS - 1);
      r_is_read            <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      mem_read_valid       <= 1'b0;
      mem_write_valid      <= 1'b0;
      mem_read_address     <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      busy                 <= 1'b0;
`ifdef MEM_ARBITER_PERF_COUNT_EN
      grant_count          <= 16'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_is_read    <= w_grant_is_read;
            busy         <= 1'b1;
`ifdef MEM_ARBITER_PERF_COUNT_EN
            grant_count  <= grant_count + 16'd1;
`endif
            // A consumer asking for both gets its read served first.
            if (w_grant_is_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[int'(w_grant_idx)*ADDR_BITS +: ADDR_BITS];
              r_state          <= READ_WAIT;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[int'(w_grant_idx)*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[int'(w_grant_idx)*DATA_BITS +: DATA_BITS];
              r_state           <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                                          <= 1'b0;
            consumer_read_data[int'(r_grant)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[r_grant]                            <= 1'b1;
            r_state                                                 <= RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid               <= 1'b0;
            consumer_write_ready[r_grant] <= 1'b1;
            r_state                       <= RELAY;
          end
        end
        RELAY: begin
          // Hold ready until the consumer withdraws its request; no grant on this edge.
          if (!w_relay_valid) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            busy                 <= 1'b0;
            r_state              <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued as requests are
// raised and checked as the downstream request and consumer completion appear.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    crv, cwv;
  logic [N*AW-1:0] craddr, cwaddr;
  logic [N*DW-1:0] cwdata;
  logic [N-1:0]    c_rd_rdy, c_wr_rdy;
  logic [N*DW-1:0] c_rdata;
  logic            mem_read_valid, mem_write_valid;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_read_ready, mem_write_ready;
  logic [DW-1:0]   mem_read_data;
  logic            busy;
`ifdef MEM_ARBITER_PERF_COUNT_EN
  logic [15:0]     grant_count;
`endif

  typedef struct packed {
    logic [1:0] cons;
    logic       is_read;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_grants = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (crv),
    .consumer_write_valid   (cwv),
    .consumer_read_address  (craddr),
    .consumer_write_address (cwaddr),
    .consumer_write_data    (cwdata),
    .consumer_read_ready    (c_rd_rdy),
    .consumer_write_ready   (c_wr_rdy),
    .consumer_read_data     (c_rdata),
    .mem_read_valid         (mem_read_valid),
    .mem_write_valid        (mem_write_valid),
    .mem_read_address       (mem_read_address),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_read_ready         (mem_read_ready),
    .mem_write_ready        (mem_write_ready),
    .mem_read_data          (mem_read_data),
    .busy                   (busy)
`ifdef MEM_ARBITER_PERF_COUNT_EN
    ,
    .grant_count            (grant_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_read(input int c, input logic [7:0] a, input logic [7:0] d);
    craddr[c*AW +: AW] = a;
    crv[c] = 1'b1;
    exp_q.push_back('{cons: 2'(c), is_read: 1'b1, addr: a, wdata: 8'h00, rdata: d});
  endtask

  task automatic push_write(input int c, input logic [7:0] a, input logic [7:0] d);
    cwaddr[c*AW +: AW] = a;
    cwdata[c*DW +: DW] = d;
    cwv[c] = 1'b1;
    exp_q.push_back('{cons: 2'(c), is_read: 1'b0, addr: a, wdata: d, rdata: 8'h00});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    crv = '0;
    cwv = '0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_grants = 0;
    exp_q.delete();
  endtask

  // Waits for the next downstream request, answers it after lat cycles, then
  // holds the consumer valid hold more cycles before dropping it.
  task automatic serve_one(input int lat, input int hold);
    exp_t         e;
    int           waited;
    logic [N-1:0] onehot;
    waited = 0;
    while (!(mem_read_valid || mem_write_valid) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("grant_seen", 32'(mem_read_valid | mem_write_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    n_grants++;
    check_eq("dir", 32'(mem_read_valid), 32'(e.is_read));
    if (e.is_read) begin
      check_eq("rd_addr", 32'(mem_read_address), 32'(e.addr));
    end else begin
      check_eq("wr_addr", 32'(mem_write_address), 32'(e.addr));
      check_eq("wr_data", 32'(mem_write_data), 32'(e.wdata));
    end
    check_eq("busy_on", 32'(busy), 32'd1);
    // Wrong-direction ready during the wait must be ignored.
    if (e.is_read) mem_write_ready = 1'b1;
    else           mem_read_ready  = 1'b1;
    repeat (lat) @(negedge clk);
    check_eq("early_rdy", 32'({c_rd_rdy, c_wr_rdy}), 32'd0);
    check_eq("addr_hold", 32'(e.is_read ? mem_read_address : mem_write_address), 32'(e.addr));
    mem_read_ready  = e.is_read;
    mem_write_ready = !e.is_read;
    mem_read_data   = e.rdata;
    @(negedge clk);
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    onehot = '0;
    onehot[e.cons] = 1'b1;
    check_eq("rd_rdy", 32'(c_rd_rdy), e.is_read ? 32'(onehot) : 32'd0);
    check_eq("wr_rdy", 32'(c_wr_rdy), e.is_read ? 32'd0 : 32'(onehot));
    check_eq("mem_valid_drop", 32'(mem_read_valid | mem_write_valid), 32'd0);
    if (e.is_read) check_eq("rd_data", 32'(c_rdata[int'(e.cons)*DW +: DW]), 32'(e.rdata));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("rdy_hold", 32'(c_rd_rdy | c_wr_rdy), 32'(onehot));
    end
    if (e.is_read) crv[e.cons] = 1'b0;
    else           cwv[e.cons] = 1'b0;
    @(negedge clk);
    check_eq("rdy_clear", 32'({c_rd_rdy, c_wr_rdy}), 32'd0);
    check_eq("busy_off", 32'(busy), 32'd0);
    check_eq("no_grant_e2", 32'(mem_read_valid | mem_write_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    reset = 1'b1;
    crv = '0;
    cwv = '0;
    craddr = '0;
    cwaddr = '0;
    cwdata = '0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check_eq("rst_mem_valid", 32'({mem_read_valid, mem_write_valid, busy}), 32'd0);
    check_eq("rst_rdy", 32'({c_rd_rdy, c_wr_rdy}), 32'd0);
    check_eq("rst_addr", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
    check_eq("rst_rdata", c_rdata, 32'd0);
`ifdef MEM_ARBITER_PERF_COUNT_EN
    check_eq("rst_gcount", 32'(grant_count), 32'd0);
`endif

    // Single read from consumer 2, memory answers after 3 cycles
    push_read(2, 8'h10, 8'hAB);
    serve_one(3, 2);
    repeat (3) @(negedge clk);
    check_eq("rdata2_keep", 32'(c_rdata[2*DW +: DW]), 32'h0000_00AB);

    // All four read together after reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) push_read(i, 8'(8'h40 + i), 8'(8'hC0 + i));
    for (int i = 0; i < N; i++) serve_one(i, 0);
    repeat (5) @(negedge clk);
    check_eq("extra_grant", 32'(mem_read_valid | mem_write_valid | busy), 32'd0);
    for (int i = 0; i < N; i++) check_eq("rdata_all", 32'(c_rdata[i*DW +: DW]), 32'(8'(8'hC0 + i)));

    // Write from consumer 1 beats read from consumer 3
    push_write(1, 8'h22, 8'h5A);
    push_read(3, 8'h07, 8'h3C);
    serve_one(2, 1);
    serve_one(1, 0);

    // Same consumer reads and writes: read first
    push_read(0, 8'h33, 8'h77);
    push_write(0, 8'h44, 8'h99);
    serve_one(1, 0);
    serve_one(1, 0);
`ifdef MEM_ARBITER_PERF_COUNT_EN
    check_eq("gcount", 32'(grant_count), 32'(n_grants));
`endif

    // Reset during READ_WAIT abandons the transaction
    push_read(2, 8'h55, 8'h00);
    waited = 0;
    while (!mem_read_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rw_grant", 32'(mem_read_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    crv = '0;
    mem_read_ready = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'({mem_read_valid, mem_write_valid, busy}), 32'd0);
    check_eq("mid_rst_rdy", 32'({c_rd_rdy, c_wr_rdy}), 32'd0);
    check_eq("mid_rst_addr", 32'({mem_read_address, mem_write_address}), 32'd0);
    mem_read_ready = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    n_grants = 0;
`ifdef MEM_ARBITER_PERF_COUNT_EN
    check_eq("gcount_rst", 32'(grant_count), 32'd0);
`endif
    @(negedge clk);
    check_eq("post_rst_rdy", 32'({c_rd_rdy, c_wr_rdy}), 32'd0);
    push_read(0, 8'h61, 8'h16);
    push_read(3, 8'h63, 8'h36);
    serve_one(0, 0);
    serve_one(2, 0);
`ifdef MEM_ARBITER_PERF_COUNT_EN
    check_eq("gcount_end", 32'(grant_count), 32'(n_grants));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
